muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO registers; the next generation of the datapath decode/execute blocks.
- Sits beside the ALU in the execute stage and is fed R-type funct codes: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Multi-cycle operations assert busy and stall the pipeline on any conflicting muldiv instruction.

Parameters:
- WIDTH, 32, operand width and HI/LO width (must be ≥4 and even).
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  execute stage holds a valid muldiv instruction.
- func  in  6  R-type funct field.
- srca  in  WIDTH  rs operand.
- srcb  in  WIDTH  rt operand.
- stall  out  1  combinational; hold the pipeline this cycle.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse after HI/LO are written by MULT/DIV.
- mf_result  out  WIDTH  combinational HI (MFHI) or LO (MFLO) value, else 0.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; HI=0, LO=0, counter=0; busy=0, done=0. Reset mid-operation aborts the operation with no partial HI/LO write.
- Funct codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. Any other func is ignored (no state change, stall=0).
- States: IDLE, MUL, DIV, FIX.
- IDLE, en=1:
  - MULT/MULTU latch |srca| and |srcb| (signed forms only; unsigned forms latch raw), plus the result signs; go to MUL, counter=WIDTH.
  - DIV/DIVU latch the same way; go to DIV, counter=WIDTH.
  - MTHI/MTLO write srca to HI/LO at that edge.
  - MFHI/MFLO are served combinationally via mf_result.
- MUL: radix-2 shift-add, one product bit per cycle into a 2*WIDTH accumulator. Counter decrements; at 1, go to FIX.
- DIV: restoring division, one quotient bit per cycle. Counter decrements; at 1, go to FIX.
- FIX: apply sign correction and write HI/LO; go to IDLE; done=1 for the next cycle.
  - Multiply: product negated if the signs differ.
  - Divide: quotient negated if the signs differ; remainder takes the sign of srca.
  - Result: HI=product[2W-1:W], LO=product[W-1:0]; for divide, LO=quotient, HI=remainder.
- Latency: issue edge E0; HI/LO written at edge E(WIDTH+1). busy is high from after E0 through E(WIDTH+1), i.e. WIDTH+1 cycles.
- stall = busy & en & (func is any of the eight codes), including MF*/MT*. Instructions issued while stalled are not accepted.
- Divide by zero: no trap; completes with normal latency; LO={WIDTH{1}}, HI=srca.
- Signed overflow MIN/−1: LO=MIN, HI=0; this is the natural result of magnitude arithmetic and needs no special case.
- mf_result is valid only when stall=0. It reads current HI/LO, so an MT* in the same cycle is not forwarded.
- busy=1 and en=0: the operation continues undisturbed.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: in MUL, when the remaining unshifted multiplier bits are all zero, skip to FIX on the next edge. Latency is then 2..WIDTH+1 cycles, and done still pulses. DIV is unaffected.
- Undefined: fixed WIDTH+1 cycle latency for all MULT/DIV.

Decomposition:
- Package muldiv_pkg: the eight funct localparams, the state encoding (IDLE, MUL, DIV, FIX) and the DIV0_LO constant.
- One sub-module is natural: muldiv_signfix, the combinational abs/negate used at latch and in FIX.
- The control FSM and the datapath stay in muldiv_unit.

Test Plan:
- MULTU srca=FFFFFFFF, srcb=00000002 → stall with en during 33 busy cycles; done pulse; MFHI=00000001, MFLO=FFFFFFFE.
- MULT srca=FFFFFFFD (−3), srcb=00000005 → HI=FFFFFFFF, LO=FFFFFFF1.
- DIV srca=FFFFFFF9 (−7), srcb=00000002 → LO=FFFFFFFD, HI=FFFFFFFF. DIVU same operands → LO=7FFFFFFC, HI=00000001.
- DIVU srca=12345678, srcb=0 → LO=FFFFFFFF, HI=12345678 after 33 cycles. DIV 80000000/FFFFFFFF → LO=80000000, HI=0.
- MTHI AAAA5555 then MFHI next cycle → mf_result=AAAA5555 with stall=0. MFLO issued during MULT busy → stall=1 every cycle until done, then returns the new LO.
- Start MULT, pull reset_n low at cycle 10 → busy=0 immediately and HI=LO=0. A new MULT after release completes correctly. With MULDIV_EARLY_OUT_EN, MULTU 5×1 → done within 3 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: funct codes, FSM state
// encoding and the divide-by-zero quotient fill value.
package muldiv_pkg;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   // Every bit of LO is set to this value on a divide by zero.
   localparam logic DIV0_LO = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_e;

   function automatic logic is_muldiv_func(input logic [5:0] f);
      case (f)
         F_MFHI, F_MTHI, F_MFLO, F_MTLO,
         F_MULT, F_MULTU, F_DIV, F_DIVU: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: takes magnitudes at issue and
// restores result signs in the fix-up cycle.
module muldiv_signfix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_val,
   input  logic             i_neg,
   output logic [WIDTH-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + {{(WIDTH-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers (shift-add multiply,
// restoring divide). Optional macro MULDIV_EARLY_OUT_EN enables multiply early-out.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [5:0]       func,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] mf_result
);

   state_e               r_state;
   state_e               w_state_nxt;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_done;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplr;
   logic [2*WIDTH-1:0]   r_acc;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic                 r_dz;
   logic                 r_op_div;

   logic                 w_signed;
   logic                 w_mul_early;
   logic [WIDTH-1:0]     w_abs_a;
   logic [WIDTH-1:0]     w_abs_b;
   logic [2*WIDTH-1:0]   w_mul_acc;
   logic [WIDTH:0]       w_trial;
   logic                 w_ge;
   logic [WIDTH-1:0]     w_diff;
   logic [WIDTH-1:0]     w_rem_nxt;
   logic [2*WIDTH-1:0]   w_prod_fix;
   logic [WIDTH-1:0]     w_quot_fix;
   logic [WIDTH-1:0]     w_rem_fix;

   assign w_signed = (func == F_MULT) || (func == F_DIV);
   assign busy     = (r_state != ST_IDLE);
   assign done     = r_done;
   assign stall    = busy & en & is_muldiv_func(func);

   muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (
      .i_val (srca),
      .i_neg (w_signed & srca[WIDTH-1]),
      .o_val (w_abs_a)
   );

   muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (
      .i_val (srcb),
      .i_neg (w_signed & srcb[WIDTH-1]),
      .o_val (w_abs_b)
   );

   muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
      .i_val (r_acc),
      .i_neg (r_neg_q),
      .o_val (w_prod_fix)
   );

   muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quot (
      .i_val (r_mplr),
      .i_neg (r_neg_q),
      .o_val (w_quot_fix)
   );

   muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
      .i_val (r_acc[WIDTH-1:0]),
      .i_neg (r_neg_r),
      .o_val (w_rem_fix)
   );

   // Multiply step adds the left-shifted multiplicand; divide step trial-subtracts.
   assign w_mul_acc = r_acc + (r_mplr[0] ? r_mcand : {(2*WIDTH){1'b0}});
   assign w_trial   = {r_acc[WIDTH-1:0], r_mplr[WIDTH-1]};
   assign w_ge      = (w_trial >= {1'b0, r_mcand[WIDTH-1:0]});
   assign w_diff    = w_trial[WIDTH-1:0] - r_mcand[WIDTH-1:0];
   assign w_rem_nxt = w_ge ? w_diff : w_trial[WIDTH-1:0];

`ifdef MULDIV_EARLY_OUT_EN
   assign w_mul_early = (r_mplr[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
   assign w_mul_early = 1'b0;
`endif

   // HI/LO read port for MFHI/MFLO.
   always_comb begin
      mf_result = {WIDTH{1'b0}};
      case (func)
         F_MFHI:  mf_result = r_hi;
         F_MFLO:  mf_result = r_lo;
         default: mf_result = {WIDTH{1'b0}};
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (en && ((func == F_MULT) || (func == F_MULTU))) begin
               w_state_nxt = ST_MUL;
            end else if (en && ((func == F_DIV) || (func == F_DIVU))) begin
               w_state_nxt = ST_DIV;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_MUL: begin
            if ((r_cnt == CNT_W'(1)) || w_mul_early) begin
               w_state_nxt = ST_FIX;
            end else begin
               w_state_nxt = ST_MUL;
            end
         end
         ST_DIV: begin
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = ST_FIX;
            end else begin
               w_state_nxt = ST_DIV;
            end
         end
         ST_FIX:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: operand latch, iteration, sign fix-up and HI/LO writeback.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hi     <= {WIDTH{1'b0}};
         r_lo     <= {WIDTH{1'b0}};
         r_cnt    <= {CNT_W{1'b0}};
         r_done   <= 1'b0;
         r_mcand  <= {(2*WIDTH){1'b0}};
         r_mplr   <= {WIDTH{1'b0}};
         r_acc    <= {(2*WIDTH){1'b0}};
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
         r_op_div <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (en) begin
                  case (func)
                     F_MTHI: r_hi <= srca;
                     F_MTLO: r_lo <= srca;
                     F_MULT, F_MULTU: begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                        r_mplr   <= w_abs_b;
                        r_acc    <= {(2*WIDTH){1'b0}};
                        r_cnt    <= CNT_W'(WIDTH);
                        r_neg_q  <= w_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        r_neg_r  <= w_signed & srca[WIDTH-1];
                        r_dz     <= 1'b0;
                        r_op_div <= 1'b0;
                     end
                     F_DIV, F_DIVU: begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs_b};
                        r_mplr   <= w_abs_a;
                        r_acc    <= {(2*WIDTH){1'b0}};
                        r_cnt    <= CNT_W'(WIDTH);
                        r_neg_q  <= w_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        r_neg_r  <= w_signed & srca[WIDTH-1];
                        r_dz     <= (srcb == {WIDTH{1'b0}});
                        r_op_div <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               r_acc   <= w_mul_acc;
               r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
               r_mplr  <= {1'b0, r_mplr[WIDTH-1:1]};
               r_cnt   <= r_cnt - CNT_W'(1);
            end
            ST_DIV: begin
               r_acc  <= {{WIDTH{1'b0}}, w_rem_nxt};
               r_mplr <= {r_mplr[WIDTH-2:0], w_ge};
               r_cnt  <= r_cnt - CNT_W'(1);
            end
            ST_FIX: begin
               // Divide by zero overrides the quotient; the remainder already equals srca.
               if (r_op_div) begin
                  r_lo <= r_dz ? {WIDTH{DIV0_LO}} : w_quot_fix;
                  r_hi <= w_rem_fix;
               end else begin
                  r_lo <= w_prod_fix[WIDTH-1:0];
                  r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
               end
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
